// File: rtl/up_counter_ctrl_pkg.sv
// Shared definitions for the up/down counter family.
//   MODE_WRAP / MODE_SAT : values for the SATURATE parameter.
//   term_value()         : terminal count (MODULO-1) as a 16-bit value.
//                          Callers slice it down to their own WIDTH.
package up_counter_ctrl_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  localparam int MAX_WIDTH = 16;

  // Terminal value of a modulo-N counter. A MODULO of 2^WIDTH gives all
  // ones in the low WIDTH bits, so the compare and the carry-out agree.
  function automatic logic [MAX_WIDTH-1:0] term_value(input int modulo);
    int tv;
    tv = modulo - 1;
    return tv[MAX_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/dff.sv
// Single-bit D flip-flop with asynchronous active-high reset to 0.
//   clk : rising-edge clock
//   rst : asynchronous reset, forces q=0 while high
//   d   : data in
//   q   : registered data out
module dff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule

// File: rtl/up_count_next.sv
// Combinational next-state logic for up_counter_ctrl.
// Priority is clr > load > en > hold.
//   count        : current registered count
//   en/clr/load  : control inputs
//   load_val     : parallel load value
//   next_count   : count for the next edge
//   term_evt     : an enabled increment at the terminal value (MODULO-1)
//   load_illegal : a load of a value >= MODULO (clamped to MODULO-1)
module up_count_next
  import up_counter_ctrl_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULO   = 8,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             term_evt,
  output logic             load_illegal
);

  localparam logic [MAX_WIDTH-1:0] TERM_FULL = term_value(MODULO);
  localparam logic [WIDTH-1:0]     TERM      = TERM_FULL[WIDTH-1:0];

  always_comb begin
    next_count   = count;
    term_evt     = 1'b0;
    load_illegal = 1'b0;
    if (clr) begin
      next_count = '0;
    end else if (load) begin
      // load_val >= MODULO is the same as load_val > MODULO-1; when
      // MODULO == 2^WIDTH this can never be true.
      if (load_val > TERM) begin
        next_count   = TERM;
        load_illegal = 1'b1;
      end else begin
        next_count = load_val;
      end
    end else if (en) begin
      if (count == TERM) begin
        term_evt   = 1'b1;
        next_count = (SATURATE == MODE_SAT) ? TERM : '0;
      end else begin
        next_count = count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/up_counter_ctrl.sv
// Binary up-counter with enable, synchronous clear, parallel load,
// programmable modulus, wrap/saturate mode, terminal-count pulse and a
// sticky overflow flag. All state lives in single-bit dff cells; every
// output is registered.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset (count=0, tc=0, ovf=0)
//   en       : increment by one per cycle
//   clr      : synchronous clear of count and tc (ovf untouched)
//   load     : synchronous parallel load of load_val
//   load_val : load value; values >= MODULO clamp to MODULO-1 and set ovf
//   ovf_clr  : synchronous clear of ovf; a same-cycle set wins
//   count    : current count
//   tc       : high for one cycle after each terminal event
//   ovf      : sticky overflow / illegal-load flag
module up_counter_ctrl
  import up_counter_ctrl_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULO   = 8,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] count_d, count_q;
  logic             tc_d, tc_q;
  logic             ovf_d, ovf_q;
  logic             term_evt;
  logic             load_illegal;

  up_count_next #(
    .WIDTH   (WIDTH),
    .MODULO  (MODULO),
    .SATURATE(SATURATE)
  ) u_next (
    .count       (count_q),
    .en          (en),
    .clr         (clr),
    .load        (load),
    .load_val    (load_val),
    .next_count  (count_d),
    .term_evt    (term_evt),
    .load_illegal(load_illegal)
  );

  always_comb begin
    tc_d  = term_evt;
    // Set sources override ovf_clr; clr alone leaves ovf as it is.
    ovf_d = term_evt | load_illegal | (ovf_q & ~ovf_clr);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_count_bit
    dff u_bit (.clk(clk), .rst(rst), .d(count_d[i]), .q(count_q[i]));
  end

  dff u_tc  (.clk(clk), .rst(rst), .d(tc_d),  .q(tc_q));
  dff u_ovf (.clk(clk), .rst(rst), .d(ovf_d), .q(ovf_q));

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Three counters share one stimulus stream: (8, wrap), (6, wrap), (6, sat).
// The driver updates a spec-level model and queues the expected outputs,
// tagged with the clock edge they belong to; a negedge monitor pops and
// compares them.
module tb_up_counter_ctrl;

  localparam int NI = 3;
  localparam int EW = NI * 5;
  localparam int MODS [NI] = '{8, 6, 6};
  localparam int SATS [NI] = '{0, 0, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, clr = 1'b0, load = 1'b0, ovf_clr = 1'b0;
  logic [2:0] load_val = '0;
  logic [2:0] count [NI];
  logic       tc [NI];
  logic       ovf [NI];

  up_counter_ctrl #(.WIDTH(3), .MODULO(8), .SATURATE(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr),
    .count(count[0]), .tc(tc[0]), .ovf(ovf[0]));
  up_counter_ctrl #(.WIDTH(3), .MODULO(6), .SATURATE(0)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr),
    .count(count[1]), .tc(tc[1]), .ovf(ovf[1]));
  up_counter_ctrl #(.WIDTH(3), .MODULO(6), .SATURATE(1)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr),
    .count(count[2]), .tc(tc[2]), .ovf(ovf[2]));

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int            tag_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  // reference model state
  int m_cnt [NI];
  int m_tc  [NI];
  int m_ovf [NI];

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end
  endtask

  // One clock edge of stimulus; the model follows the textual rules.
  task automatic step(input logic e, input logic c, input logic l,
                      input logic [2:0] lv, input logic oc);
    logic [EW-1:0] e_vec;
    @(posedge clk);
    #2;
    en = e; clr = c; load = l; load_val = lv; ovf_clr = oc;
    for (int i = 0; i < NI; i++) begin
      int m;
      bit set;
      m   = MODS[i];
      set = 0;
      if (c) begin
        m_cnt[i] = 0; m_tc[i] = 0;
      end else if (l) begin
        if (int'(lv) >= m) begin
          m_cnt[i] = m - 1; set = 1;
        end else begin
          m_cnt[i] = int'(lv);
        end
        m_tc[i] = 0;
      end else if (e) begin
        if (m_cnt[i] == m - 1) begin
          m_cnt[i] = SATS[i] ? m - 1 : 0;
          m_tc[i]  = 1; set = 1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1; m_tc[i] = 0;
        end
      end else begin
        m_tc[i] = 0;
      end
      if (set)     m_ovf[i] = 1;
      else if (oc) m_ovf[i] = 0;
      e_vec[i*5 +: 5] = {3'(m_cnt[i]), 1'(m_tc[i]), 1'(m_ovf[i])};
    end
    exp_q.push_back(e_vec);
    tag_q.push_back(cyc + 1);
  endtask

  task automatic idle();
    en = 1'b0; clr = 1'b0; load = 1'b0; ovf_clr = 1'b0; load_val = '0;
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      while (tag_q.size() > 0 && tag_q[0] <= cyc) begin
        logic [EW-1:0] e_vec;
        e_vec = exp_q.pop_front();
        void'(tag_q.pop_front());
        for (int i = 0; i < NI; i++) begin
          check($sformatf("count[%0d]", i), int'(count[i]), int'(e_vec[i*5+2 +: 3]));
          check($sformatf("tc[%0d]", i),    int'(tc[i]),    int'(e_vec[i*5+1]));
          check($sformatf("ovf[%0d]", i),   int'(ovf[i]),   int'(e_vec[i*5]));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_count[%0d]", tag, i), int'(count[i]), 0);
      check($sformatf("%s_tc[%0d]", tag, i),    int'(tc[i]),    0);
      check($sformatf("%s_ovf[%0d]", tag, i),   int'(ovf[i]),   0);
    end
  endtask

  initial begin
    model_reset();
    // inputs garbage while in reset must not matter
    en = 1'bx; clr = 1'bx; load = 1'bx;
    #3;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #3;
    check_reset_outputs("por_hold");
    idle();
    @(negedge clk);
    rst = 1'b0;

    // count to 5 on the default counter, then reset mid-count
    repeat (5) step(1, 0, 0, 3'd0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    idle();
    check("pre_rst_count0", int'(count[0]), 5);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    en = 1'bx;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    idle();
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // wrap sequence: 1..7,0,1 / MODULO 6 wrap and saturate
    repeat (9) step(1, 0, 0, 3'd0, 0);
    // illegal load on the MODULO-6 counters, legal on the default one
    step(0, 0, 1, 3'd7, 0);
    step(0, 0, 0, 3'd0, 1);
    // saturate run from 0
    step(0, 1, 0, 3'd0, 0);
    repeat (8) step(1, 0, 0, 3'd0, 0);

    // priority: count=3, then clr+load+en, load+en, en
    step(0, 0, 1, 3'd3, 0);
    step(1, 1, 1, 3'd6, 0);
    step(1, 0, 1, 3'd6, 0);
    step(1, 0, 0, 3'd0, 0);

    // ovf set/clear race at count=7 on the default counter
    step(0, 0, 0, 3'd0, 1);
    step(0, 0, 1, 3'd7, 0);
    step(1, 0, 0, 3'd0, 1);
    step(0, 0, 0, 3'd0, 1);

    // hold at 4
    step(0, 0, 1, 3'd4, 0);
    repeat (5) step(0, 0, 0, 3'd0, 0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      logic e, c, l, oc;
      logic [2:0] lv;
      e  = ($urandom_range(0, 99) < 70);
      c  = ($urandom_range(0, 99) < 5);
      l  = ($urandom_range(0, 99) < 10);
      oc = ($urandom_range(0, 99) < 10);
      lv = 3'($urandom_range(0, 7));
      step(e, c, l, lv, oc);
    end

    // drain with a bounded wait
    for (int k = 0; k < 10 && tag_q.size() > 0; k++) @(negedge clk);
    #1;
    check("scoreboard_drained", tag_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
